// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit timebase: FSM state encodings,
// default oversampling / frame geometry and a small helper for the mid-slot point.
// Optional feature macro used by the timer: TX_TWO_STOP_EN (adds the stop2 port).
package uart_pkg;

  // Frame timer states: waiting for a write, or stepping through bit slots.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

  // 16x oversampling, 1 start + 8 data + 1 parity + 1 stop.
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_FRAME_BITS = 11;

  // Counter value whose enable produces the mid-slot strobe (integer halving).
  function automatic int mid_point(input int oversample);
    return (oversample / 2) - 1;
  endfunction

  // Highest counter value inside one bit slot.
  function automatic int slot_last(input int oversample);
    return oversample - 1;
  endfunction

endpackage

// File: rtl/tx_bit_slot_counter.sv
// Modulo-OVERSAMPLE position counter inside one bit slot.
// clear forces the count back to zero; enable advances it by one and wraps
// at OVERSAMPLE-1. wrap and mid flag the enable that finishes the slot and
// the enable that reaches the middle of the slot, respectively.
module tx_bit_slot_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  localparam int CNT_W = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             mid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(slot_last(OVERSAMPLE));
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_point(OVERSAMPLE));

  // Decode the slot-end and mid-slot events for the enable being applied now.
  always_comb begin
    wrap = 1'b0;
    mid  = 1'b0;
    if (enable) begin
      wrap = (cnt == CNT_LAST);
      mid  = (cnt == CNT_MID);
    end else begin
      wrap = 1'b0;
      mid  = 1'b0;
    end
  end

  // Position register: clear wins over enable, wrap back to zero at the slot end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt <= {CNT_W{1'b0}};
    end else if (enable) begin
      if (cnt >= CNT_LAST) begin
        cnt <= {CNT_W{1'b0}};
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/tx_frame_timer_checker.sv
// Structural invariants of the frame timer outputs, kept apart from the datapath.
module tx_frame_timer_checker #(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 11,
  parameter int CNT_W      = 4,
  parameter int IDX_W      = 4
) (
  input logic             clk,
  input logic             reset,
  input logic [CNT_W-1:0] sample_cnt,
  input logic [IDX_W-1:0] bit_idx,
  input logic             bit_tick,
  input logic             mid_tick,
  input logic             busy,
  input logic             frame_done
);

  // A completed frame is always reported together with its last bit boundary.
  done_has_tick: assert property (@(posedge clk) disable iff (reset)
    frame_done |-> bit_tick);

  // The timer is idle in the cycle it reports completion.
  done_not_busy: assert property (@(posedge clk) disable iff (reset)
    frame_done |-> !busy);

  // Boundary and middle of a slot can never fall on the same enable.
  ticks_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(bit_tick && mid_tick));

  // Counters stay within their ranges.
  cnt_in_range: assert property (@(posedge clk) disable iff (reset)
    sample_cnt <= CNT_W'(OVERSAMPLE - 1));
  idx_in_range: assert property (@(posedge clk) disable iff (reset)
    bit_idx <= IDX_W'(FRAME_BITS));

endmodule

// File: rtl/tx_frame_timer.sv
// UART transmit frame timer. Counts oversampled sample_ENABLE strobes into
// bit slots and frames, producing bit-boundary / mid-bit strobes, the bit
// index, busy and a frame-done pulse so Tx shifting and Rx sync share one timebase.
// Optional feature macro: TX_TWO_STOP_EN -- adds the stop2 input; when it is
// captured high on a Tx_WR edge the frame carries one extra stop slot.
module tx_frame_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
  localparam int CNT_W = $clog2(OVERSAMPLE),
  localparam int IDX_W = $clog2(FRAME_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_ENABLE,
  input  logic             Tx_WR,
`ifdef TX_TWO_STOP_EN
  input  logic             stop2,
`endif
  output logic [CNT_W-1:0] sample_cnt,
  output logic [IDX_W-1:0] bit_idx,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(FRAME_BITS - 1);

  tx_state_t        state;
  logic             slot_en;
  logic             slot_wrap;
  logic             slot_mid;
  logic [IDX_W-1:0] last_idx;

`ifdef TX_TWO_STOP_EN
  logic             stop2_hold;
`endif

  // Only enables seen while running advance the slot counter; a write discards
  // any coincident enable because it restarts the frame.
  always_comb begin
    slot_en = 1'b0;
    if ((state == ST_RUN) && !Tx_WR) begin
      slot_en = sample_ENABLE;
    end else begin
      slot_en = 1'b0;
    end
  end

  // Index of the final slot of the current frame.
`ifdef TX_TWO_STOP_EN
  always_comb begin
    last_idx = LAST_BASE;
    if (stop2_hold) begin
      last_idx = LAST_BASE + IDX_W'(1);
    end else begin
      last_idx = LAST_BASE;
    end
  end
`else
  always_comb begin
    last_idx = LAST_BASE;
  end
`endif

  tx_bit_slot_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_slot_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (Tx_WR),
    .enable (slot_en),
    .cnt    (sample_cnt),
    .wrap   (slot_wrap),
    .mid    (slot_mid)
  );

`ifdef TX_TWO_STOP_EN
  // Stop-bit count is latched at the write and held for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      stop2_hold <= 1'b0;
    end else if (Tx_WR) begin
      stop2_hold <= stop2;
    end else begin
      stop2_hold <= stop2_hold;
    end
  end
`endif

  // Frame FSM with bit index and registered strobes; a write always restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= {IDX_W{1'b0}};
      bit_tick   <= 1'b0;
      mid_tick   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_tick   <= 1'b0;
      mid_tick   <= 1'b0;
      frame_done <= 1'b0;
      if (Tx_WR) begin
        state   <= ST_RUN;
        busy    <= 1'b1;
        bit_idx <= {IDX_W{1'b0}};
      end else begin
        case (state)
          ST_IDLE: begin
            busy    <= 1'b0;
            bit_idx <= {IDX_W{1'b0}};
          end
          ST_RUN: begin
            busy     <= 1'b1;
            mid_tick <= slot_mid;
            if (slot_wrap) begin
              bit_tick <= 1'b1;
              if (bit_idx < last_idx) begin
                bit_idx <= bit_idx + IDX_W'(1);
              end else begin
                bit_idx    <= {IDX_W{1'b0}};
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end
            end else begin
              bit_idx <= bit_idx;
            end
          end
          default: begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bit_idx <= {IDX_W{1'b0}};
          end
        endcase
      end
    end
  end

  tx_frame_timer_checker #(
    .OVERSAMPLE (OVERSAMPLE),
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .sample_cnt (sample_cnt),
    .bit_idx    (bit_idx),
    .bit_tick   (bit_tick),
    .mid_tick   (mid_tick),
    .busy       (busy),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_tx_frame_timer.sv
// Self-checking bench for tx_frame_timer: directed scenarios followed by a
// randomized phase, every cycle compared against an enable-counting model.
module tb_tx_frame_timer;

  localparam int OS = 16;
  localparam int FB = 11;
  localparam int CW = $clog2(OS);
  localparam int IW = $clog2(FB + 1);
`ifdef TX_TWO_STOP_EN
  localparam bit TWO_STOP = 1'b1;
`else
  localparam bit TWO_STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_ENABLE = 1'b0;
  logic          Tx_WR = 1'b0;
  logic          stop2 = 1'b0;
  logic [CW-1:0] sample_cnt;
  logic [IW-1:0] bit_idx;
  logic          bit_tick;
  logic          mid_tick;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  tx_frame_timer #(
    .OVERSAMPLE (OS),
    .FRAME_BITS (FB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_ENABLE (sample_ENABLE),
    .Tx_WR         (Tx_WR),
`ifdef TX_TWO_STOP_EN
    .stop2         (stop2),
`endif
    .sample_cnt    (sample_cnt),
    .bit_idx       (bit_idx),
    .bit_tick      (bit_tick),
    .mid_tick      (mid_tick),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is just a count of accepted enables.
  bit m_run = 1'b0;
  int m_n = 0;
  int m_slots = FB;
  int e_cnt = 0;
  int e_idx = 0;
  bit e_bt = 1'b0;
  bit e_mt = 1'b0;
  bit e_busy = 1'b0;
  bit e_done = 1'b0;

  // Per-scenario tallies.
  int en_cnt = 0;
  int bt_cnt = 0;
  bit done_seen = 1'b0;
  int first_mid = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit wr, input bit se);
    e_bt   = 1'b0;
    e_mt   = 1'b0;
    e_done = 1'b0;
    if (r) begin
      m_run  = 1'b0;
      m_n    = 0;
      e_busy = 1'b0;
      e_cnt  = 0;
      e_idx  = 0;
    end else if (wr) begin
      m_run   = 1'b1;
      m_n     = 0;
      m_slots = FB + ((TWO_STOP && stop2) ? 1 : 0);
      e_busy  = 1'b1;
      e_cnt   = 0;
      e_idx   = 0;
    end else if (m_run && se) begin
      en_cnt++;
      m_n++;
      e_cnt = m_n % OS;
      e_mt  = (((m_n - 1) % OS) == (OS / 2 - 1));
      e_bt  = (e_cnt == 0);
      e_idx = m_n / OS;
      if (m_n == m_slots * OS) begin
        m_run  = 1'b0;
        m_n    = 0;
        e_busy = 1'b0;
        e_done = 1'b1;
        e_idx  = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit wr, input bit se);
    reset         = r;
    Tx_WR         = wr;
    sample_ENABLE = se;
    @(posedge clk);
    model_update(r, wr, se);
    #1;
    check("sample_cnt", 32'(sample_cnt), e_cnt);
    check("bit_idx", 32'(bit_idx), e_idx);
    check("bit_tick", 32'(bit_tick), 32'(e_bt));
    check("mid_tick", 32'(mid_tick), 32'(e_mt));
    check("busy", 32'(busy), 32'(e_busy));
    check("frame_done", 32'(frame_done), 32'(e_done));
    if (bit_tick === 1'b1) bt_cnt++;
    if (frame_done === 1'b1) done_seen = 1'b1;
    if ((mid_tick === 1'b1) && (first_mid < 0)) first_mid = int'(sample_cnt);
  endtask

  task automatic clear_stats();
    en_cnt    = 0;
    bt_cnt    = 0;
    done_seen = 1'b0;
    first_mid = -1;
  endtask

  task automatic start_frame();
    step(1'b0, 1'b1, 1'b0);
    clear_stats();
  endtask

  // Feed enables every 'period' cycles until the DUT reports frame_done (bounded).
  task automatic run_frame(input int period, input bit toggle_s2, input int limit);
    for (int i = 0; (i < limit) && !done_seen; i++) begin
      if (toggle_s2) stop2 = 1'($urandom % 2);
      step(1'b0, 1'b0, (i % period) == (period - 1));
    end
  endtask

  task automatic run_to_idx(input int idx);
    for (int i = 0; (i < 300) && (e_idx != idx); i++) begin
      step(1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    // Reset state.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(bit_idx), 32'd0);

    // 1: enable every cycle.
    start_frame();
    check("s1_busy_after_wr", 32'(busy), 32'd1);
    run_frame(1, 1'b0, 400);
    check("s1_done", 32'(done_seen), 32'd1);
    check("s1_enables", en_cnt, FB * OS);
    check("s1_bit_ticks", bt_cnt, FB);
    check("s1_busy_end", 32'(busy), 32'd0);

    // 2: enable every 4th cycle.
    start_frame();
    run_frame(4, 1'b0, 1000);
    check("s2_done", 32'(done_seen), 32'd1);
    check("s2_enables", en_cnt, FB * OS);
    check("s2_first_mid_cnt", first_mid, OS / 2);

    // 3: restart at bit 5 with a coincident enable.
    start_frame();
    run_to_idx(5);
    check("s3_reached_idx5", 32'(bit_idx), 32'd5);
    step(1'b0, 1'b1, 1'b1);
    clear_stats();
    check("s3_restart_idx", 32'(bit_idx), 32'd0);
    check("s3_restart_cnt", 32'(sample_cnt), 32'd0);
    check("s3_restart_done", 32'(frame_done), 32'd0);
    run_frame(1, 1'b0, 400);
    check("s3_done", 32'(done_seen), 32'd1);
    check("s3_enables", en_cnt, FB * OS);

    // 4: reset at bit 3, then idle enables, then a clean start.
    start_frame();
    run_to_idx(3);
    step(1'b1, 1'b0, 1'b1);
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_idx", 32'(bit_idx), 32'd0);
    check("s4_rst_cnt", 32'(sample_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    check("s4_idle_cnt", 32'(sample_cnt), 32'd0);
    start_frame();
    run_frame(1, 1'b0, 400);
    check("s4_enables", en_cnt, FB * OS);

    // 5: write coincident with the final enable.
    start_frame();
    for (int i = 0; i < FB * OS - 1; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("s5_no_done", 32'(frame_done), 32'd0);
    check("s5_busy", 32'(busy), 32'd1);
    check("s5_no_tick", 32'(bit_tick), 32'd0);
    check("s5_idx", 32'(bit_idx), 32'd0);
    clear_stats();
    run_frame(1, 1'b0, 400);
    check("s5_enables", en_cnt, FB * OS);

`ifdef TX_TWO_STOP_EN
    // 6: two stop bits, stop2 wiggled after the write.
    stop2 = 1'b1;
    start_frame();
    run_frame(1, 1'b1, 400);
    check("s6_two_enables", en_cnt, (FB + 1) * OS);
    check("s6_two_ticks", bt_cnt, FB + 1);
    stop2 = 1'b0;
    start_frame();
    run_frame(1, 1'b1, 400);
    check("s6_one_enables", en_cnt, FB * OS);
`endif

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      stop2 = 1'($urandom % 2);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 399) == 0), (($urandom % 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
